// File: rtl/irs3b_pkg.sv
// Shared widths, FSM encoding and test-pattern packing for the IRS3B
// readout-address receiver.
package irs3b_pkg;

    localparam int IRS_ADDR_W = 9;
    localparam int IRS_CH_W   = 3;
    localparam int IRS_SMP_W  = 6;
    localparam int IRS_DAT_W  = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_SETTLE = 2'd2
    } irs_state_t;

    // Test-pattern word: {spare 0, stack id, address}.
    function automatic logic [IRS_DAT_W-1:0] irs_pack_pattern(
        input logic [1:0]            stack,
        input logic [IRS_ADDR_W-1:0] addr
    );
        return {1'b0, stack, addr};
    endfunction

endpackage

// File: rtl/irs_input_sync.sv
// SYNC_STAGES-deep synchroniser for one IRS3B serial-interface line, followed
// by a history flop for rise/fall detection. SYNC_STAGES=0 bypasses the chain.
module irs_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic sync_o,
    output logic hist_o,
    output logic rise_o,
    output logic fall_o
);

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign sync_o = d_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] chain_q;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    chain_q <= '0;
                end else begin
                    chain_q[0] <= d_i;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        chain_q[i] <= chain_q[i-1];
                    end
                end
            end

            assign sync_o = chain_q[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hist_o <= 1'b0;
        end else begin
            hist_o <= sync_o;
        end
    end

    assign rise_o = sync_o & ~hist_o;
    assign fall_o = ~sync_o & hist_o;

endmodule

// File: rtl/irs3b_readout_address_receiver.sv
// Device-side IRS3B readout-address receiver: serial start-address load, DO_SCLK
// increment, settled test-pattern output. Optional shift-count check: IRS_RX_SHIFT_COUNT_CHECK_EN.
module irs3b_readout_address_receiver
    import irs3b_pkg::*;
#(
    parameter logic [1:0] STACK_NUMBER    = 2'b00,
    parameter int         SYNC_STAGES     = 2,
    parameter int         DATA_LATENCY    = 4,
    parameter int         EXPECTED_SHIFTS = 9
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  do_dir_i,
    input  logic                  do_sin_i,
    input  logic                  do_sclk_i,
    output logic [IRS_ADDR_W-1:0] addr_o,
    output logic [IRS_CH_W-1:0]   ch_o,
    output logic [IRS_SMP_W-1:0]  smp_o,
    output logic [IRS_DAT_W-1:0]  dat_o,
    output logic                  valid_o,
    output logic                  load_done_o,
`ifdef IRS_RX_SHIFT_COUNT_CHECK_EN
    output logic                  load_error_o,
`endif
    output logic                  busy_o
);

    localparam logic [3:0] CNT_LAST = 4'(DATA_LATENCY - 1);

    logic dir_s, dir_h, dir_rise, dir_fall;
    logic sin_s, sin_h, sin_rise, sin_fall;
    logic sclk_s, sclk_h, sclk_rise, sclk_fall;
    logic sync_unused;

    irs_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dir (
        .clk_i (clk_i), .rst_i (rst_i), .d_i (do_dir_i),
        .sync_o(dir_s), .hist_o(dir_h), .rise_o(dir_rise), .fall_o(dir_fall)
    );

    irs_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sin (
        .clk_i (clk_i), .rst_i (rst_i), .d_i (do_sin_i),
        .sync_o(sin_s), .hist_o(sin_h), .rise_o(sin_rise), .fall_o(sin_fall)
    );

    irs_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk_i (clk_i), .rst_i (rst_i), .d_i (do_sclk_i),
        .sync_o(sclk_s), .hist_o(sclk_h), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    assign sync_unused = ^{dir_s, sin_h, sin_rise, sin_fall, sclk_s, sclk_h, sclk_fall};

    // DO_DIR is judged by its history flop, so a clock edge coincident with a
    // DIR transition acts in the mode that was in force before the transition.
    logic shift_ev, inc_ev, load_ok;
    assign shift_ev = sclk_rise & dir_h;
    assign inc_ev   = sclk_rise & ~dir_h;

    irs_state_t            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IRS_ADDR_W-1:0] sr_q, sr_d;
    logic [IRS_ADDR_W-1:0] addr_q, addr_d;
    logic                  valid_q, valid_d;
    logic                  load_done_q, load_done_d;

`ifdef IRS_RX_SHIFT_COUNT_CHECK_EN
    logic [3:0] shift_cnt_q, shift_cnt_d;
    logic       load_err_q;

    always_comb begin
        shift_cnt_d = shift_cnt_q;
        if (dir_rise) begin
            shift_cnt_d = '0;
        end else if (shift_ev && (shift_cnt_q != 4'hF)) begin
            shift_cnt_d = shift_cnt_q + 4'd1;
        end
    end

    // Count includes a shift coincident with the DIR fall, matching the sr
    // value that would be transferred.
    assign load_ok = (shift_cnt_d == 4'(EXPECTED_SHIFTS));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_cnt_q <= '0;
            load_err_q  <= 1'b0;
        end else begin
            shift_cnt_q <= shift_cnt_d;
            load_err_q  <= load_err_q | (dir_fall & ~load_ok);
        end
    end

    assign load_error_o = load_err_q;
`else
    logic [3:0] cfg_unused;
    assign cfg_unused = 4'(EXPECTED_SHIFTS);
    assign load_ok    = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        addr_d      = addr_q;
        valid_d     = 1'b0;
        load_done_d = 1'b0;

        if (shift_ev) begin
            sr_d = {sin_s, sr_q[IRS_ADDR_W-1:1]};
        end
        if (inc_ev) begin
            addr_d = addr_q + 9'd1;
        end

        // Any new event supersedes a pending settle, so no valid is issued
        // for an address that has already been replaced.
        if (dir_fall) begin
            if (load_ok) begin
                addr_d      = sr_d;
                load_done_d = 1'b1;
                cnt_d       = '0;
                state_d     = ST_SETTLE;
            end else begin
                state_d     = ST_IDLE;
            end
        end else if (dir_rise) begin
            state_d = ST_SHIFT;
        end else if (inc_ev) begin
            cnt_d   = '0;
            state_d = ST_SETTLE;
        end else if (state_q == ST_SETTLE) begin
            if (cnt_q == CNT_LAST) begin
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            addr_q      <= '0;
            valid_q     <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            load_done_q <= load_done_d;
        end
    end

    assign addr_o      = addr_q;
    assign ch_o        = addr_q[IRS_ADDR_W-1:IRS_SMP_W];
    assign smp_o       = addr_q[IRS_SMP_W-1:0];
    assign dat_o       = irs_pack_pattern(STACK_NUMBER, addr_q);
    assign valid_o     = valid_q;
    assign load_done_o = load_done_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_irs3b_readout_address_receiver.sv
// Directed bench for irs3b_readout_address_receiver: table of load/increment
// vectors plus hand-written sequences for supersede, DIR-in-settle and reset.
`timescale 1ns/1ps
module tb_irs3b_readout_address_receiver;

    localparam int DL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        do_dir = 1'b0;
    logic        do_sin = 1'b0;
    logic        do_sclk = 1'b0;
    logic [8:0]  addr_o;
    logic [2:0]  ch_o;
    logic [5:0]  smp_o;
    logic [11:0] dat_o;
    logic        valid_o;
    logic        load_done_o;
    logic        busy_o;
`ifdef IRS_RX_SHIFT_COUNT_CHECK_EN
    logic        load_error_o;
`endif

    always #5 clk = ~clk;

    irs3b_readout_address_receiver #(
        .STACK_NUMBER   (2'b00),
        .SYNC_STAGES    (2),
        .DATA_LATENCY   (DL),
        .EXPECTED_SHIFTS(9)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .do_dir_i    (do_dir),
        .do_sin_i    (do_sin),
        .do_sclk_i   (do_sclk),
        .addr_o      (addr_o),
        .ch_o        (ch_o),
        .smp_o       (smp_o),
        .dat_o       (dat_o),
        .valid_o     (valid_o),
        .load_done_o (load_done_o),
`ifdef IRS_RX_SHIFT_COUNT_CHECK_EN
        .load_error_o(load_error_o),
`endif
        .busy_o      (busy_o)
    );

    // Pulse monitor: counts valid/load_done pulses and measures valid latency
    // from the most recent address update.
    int          cyc = 0;
    int          valid_cnt = 0;
    int          load_cnt = 0;
    int          upd_cyc = 0;
    int          valid_lat = 0;
    logic [11:0] valid_dat = '0;
    logic [8:0]  prev_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (load_done_o || (addr_o != prev_addr)) upd_cyc = cyc;
            if (load_done_o) load_cnt = load_cnt + 1;
            if (valid_o) begin
                valid_cnt = valid_cnt + 1;
                valid_lat = cyc - upd_cyc;
                valid_dat = dat_o;
            end
        end
        prev_addr = addr_o;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_addr(input logic [8:0] val, input int nbits);
        do_dir = 1'b1;
        wait_cyc(4);
        for (int i = 0; i < nbits; i++) begin
            do_sin = val[i];
            wait_cyc(2);
            do_sclk = 1'b1;
            wait_cyc(4);
            do_sclk = 1'b0;
            wait_cyc(4);
        end
        do_dir = 1'b0;
        wait_cyc(4);
    endtask

    task automatic inc_pulse(input int hi, input int lo);
        do_sclk = 1'b1;
        wait_cyc(hi);
        do_sclk = 1'b0;
        wait_cyc(lo);
    endtask

    typedef struct {
        logic [8:0]  load;
        int          incs;
        logic [8:0]  addr;
        logic [2:0]  ch;
        logic [5:0]  smp;
        logic [11:0] dat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int v0, l0;

        vecs[0] = '{9'h1A5, 0, 9'h1A5, 3'd6, 6'h25, 12'h1A5};
        vecs[1] = '{9'h1FE, 1, 9'h1FF, 3'd7, 6'h3F, 12'h1FF};
        vecs[2] = '{9'h1FE, 2, 9'h000, 3'd0, 6'h00, 12'h000};
        vecs[3] = '{9'h1FE, 3, 9'h001, 3'd0, 6'h01, 12'h001};
        vecs[4] = '{9'h03F, 1, 9'h040, 3'd1, 6'h00, 12'h040};
        vecs[5] = '{9'h07A, 0, 9'h07A, 3'd1, 6'h3A, 12'h07A};
        vecs[6] = '{9'h155, 2, 9'h157, 3'd5, 6'h17, 12'h157};

        // Reset state
        wait_cyc(3);
        check("rst addr_o", 32'(addr_o), 32'h0);
        check("rst dat_o", 32'(dat_o), 32'h0);
        check("rst valid_o", 32'(valid_o), 32'h0);
        check("rst load_done_o", 32'(load_done_o), 32'h0);
        check("rst busy_o", 32'(busy_o), 32'h0);
`ifdef IRS_RX_SHIFT_COUNT_CHECK_EN
        check("rst load_error_o", 32'(load_error_o), 32'h0);
`endif
        rst = 1'b0;
        wait_cyc(3);

        for (int i = 0; i < 7; i++) begin
            v0 = valid_cnt;
            l0 = load_cnt;
            load_addr(vecs[i].load, 9);
            wait_cyc(12);
            check($sformatf("v%0d load_done count", i), 32'(load_cnt - l0), 32'd1);
            for (int k = 0; k < vecs[i].incs; k++) begin
                inc_pulse(4, 4);
                wait_cyc(12);
            end
            check($sformatf("v%0d addr_o", i), 32'(addr_o), 32'(vecs[i].addr));
            check($sformatf("v%0d ch_o", i), 32'(ch_o), 32'(vecs[i].ch));
            check($sformatf("v%0d smp_o", i), 32'(smp_o), 32'(vecs[i].smp));
            check($sformatf("v%0d dat_o", i), 32'(dat_o), 32'(vecs[i].dat));
            check($sformatf("v%0d valid count", i), 32'(valid_cnt - v0), 32'(1 + vecs[i].incs));
            check($sformatf("v%0d valid dat", i), 32'(valid_dat), 32'(vecs[i].dat));
            check($sformatf("v%0d valid latency", i), 32'(valid_lat), 32'(DL));
            check($sformatf("v%0d busy_o idle", i), 32'(busy_o), 32'h0);
        end

        // Two increments two cycles apart: only the second address is validated
        v0 = valid_cnt;
        inc_pulse(1, 1);
        inc_pulse(1, 1);
        wait_cyc(20);
        check("supersede valid count", 32'(valid_cnt - v0), 32'd1);
        check("supersede addr_o", 32'(addr_o), 32'h159);
        check("supersede valid dat", 32'(valid_dat), 32'h159);
        check("supersede valid latency", 32'(valid_lat), 32'(DL));

        // DIR rising during SETTLE: no valid, address holds until next transfer
        v0 = valid_cnt;
        l0 = load_cnt;
        inc_pulse(1, 1);
        do_dir = 1'b1;
        wait_cyc(20);
        check("dir-in-settle valid count", 32'(valid_cnt - v0), 32'd0);
        check("dir-in-settle addr_o", 32'(addr_o), 32'h15A);
        check("dir-in-settle busy_o", 32'(busy_o), 32'h1);
        load_addr(9'h0F0, 9);
        wait_cyc(12);
        check("dir-in-settle reload addr_o", 32'(addr_o), 32'h0F0);
        check("dir-in-settle load_done count", 32'(load_cnt - l0), 32'd1);
        check("dir-in-settle reload valid", 32'(valid_cnt - v0), 32'd1);

        // Reset mid-shift after 5 bits
        do_dir = 1'b1;
        wait_cyc(4);
        for (int i = 0; i < 5; i++) begin
            do_sin = i[0];
            wait_cyc(2);
            do_sclk = 1'b1;
            wait_cyc(4);
            do_sclk = 1'b0;
            wait_cyc(4);
        end
        check("pre-reset busy_o", 32'(busy_o), 32'h1);
        rst = 1'b1;
        #2;
        check("mid-shift rst addr_o", 32'(addr_o), 32'h0);
        check("mid-shift rst dat_o", 32'(dat_o), 32'h0);
        check("mid-shift rst busy_o", 32'(busy_o), 32'h0);
        do_dir = 1'b0;
        do_sin = 1'b0;
        do_sclk = 1'b0;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(3);
        l0 = load_cnt;
        load_addr(9'h07A, 9);
        wait_cyc(12);
        check("post-reset load addr_o", 32'(addr_o), 32'h07A);
        check("post-reset load_done count", 32'(load_cnt - l0), 32'd1);

        // Short (8-shift) load of 0x100
        v0 = valid_cnt;
        l0 = load_cnt;
        load_addr(9'h100, 8);
        wait_cyc(12);
`ifdef IRS_RX_SHIFT_COUNT_CHECK_EN
        check("short load addr_o held", 32'(addr_o), 32'h07A);
        check("short load load_error_o", 32'(load_error_o), 32'h1);
        check("short load load_done count", 32'(load_cnt - l0), 32'd0);
        check("short load valid count", 32'(valid_cnt - v0), 32'd0);
        check("short load busy_o", 32'(busy_o), 32'h0);
`else
        // sr held 0x07A; eight zero shifts leave 0x07A >> 8 = 0
        check("short load addr_o", 32'(addr_o), 32'h000);
        check("short load load_done count", 32'(load_cnt - l0), 32'd1);
        check("short load valid count", 32'(valid_cnt - v0), 32'd1);
`endif
        l0 = load_cnt;
        load_addr(9'h0C3, 9);
        wait_cyc(12);
        check("full load after short addr_o", 32'(addr_o), 32'h0C3);
        check("full load after short load_done", 32'(load_cnt - l0), 32'd1);
`ifdef IRS_RX_SHIFT_COUNT_CHECK_EN
        check("load_error_o sticky", 32'(load_error_o), 32'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
